// File: rtl/dtm_jtag_tap_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dm (package)
// Purpose : Shared types for the debug transport module JTAG front end:
//           TAP controller state encoding, DTM instruction encodings and
//           the instruction register width.
// Revision: 1.0 - initial release
// ============================================================================
package dm;

    localparam int unsigned c_IR_WIDTH = 5;

    typedef enum logic [3:0] {
        TestLogicReset,
        RunTestIdle,
        SelectDrScan,
        CaptureDr,
        ShiftDr,
        Exit1Dr,
        PauseDr,
        Exit2Dr,
        UpdateDr,
        SelectIrScan,
        CaptureIr,
        ShiftIr,
        Exit1Ir,
        PauseIr,
        Exit2Ir,
        UpdateIr
    } tap_state_e;

    typedef enum logic [4:0] {
        BYPASS0   = 5'h00,
        IDCODE    = 5'h01,
        DTMCSR    = 5'h10,
        DMIACCESS = 5'h11,
        BYPASS1   = 5'h1F
    } dtm_ir_e;

endpackage
`default_nettype wire

// File: rtl/dtm_jtag_tap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dtm_jtag_tap
// Purpose : IEEE 1149.1 TAP controller feeding the RISC-V DTM register block.
//           Holds the 16-state TAP FSM, the instruction register and the
//           IDCODE / BYPASS data registers; muxes serial data onto TDO.
// Ports   : tck_i / trst_ni        - JTAG clock, async active-low reset
//           tms_i / td_i           - test mode select, test data in
//           td_o / tdo_oe_o        - test data out + enable (falling edge)
//           tdi_o                  - td_i forwarded to the register block
//           capture_o/shift_o/update_o - DR scan strobes
//           dtmcs_select_o / dmi_select_o - register selects from the IR
//           dmi_clear_o            - high while in TestLogicReset
//           dtmcs_tdo_i / dmi_tdo_i - serial outputs of the register block
// Revision: 1.0 - initial release
// ============================================================================
module dtm_jtag_tap
    import dm::*;
#(
    parameter int unsigned IrLength    = c_IR_WIDTH,
    parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
    input  logic tck_i,
    input  logic trst_ni,
    input  logic tms_i,
    input  logic td_i,
    output logic td_o,
    output logic tdo_oe_o,
    output logic tdi_o,
    output logic capture_o,
    output logic shift_o,
    output logic update_o,
    output logic dtmcs_select_o,
    output logic dmi_select_o,
    output logic dmi_clear_o,
    input  logic dtmcs_tdo_i,
    input  logic dmi_tdo_i
);

    tap_state_e            r_state;
    tap_state_e            w_state_next;
    logic [IrLength-1:0]   r_ir;
    logic [IrLength-1:0]   r_ir_shift;
    logic [31:0]           r_idcode;
    logic                  r_bypass;
    logic                  r_td;
    logic                  r_tdo_oe;
    logic                  w_tdo;
    logic                  w_sel_idcode;
    logic                  w_sel_dtmcs;
    logic                  w_sel_dmi;
    logic                  w_sel_bypass;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) r_state <= TestLogicReset;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            TestLogicReset: w_state_next = tms_i ? TestLogicReset : RunTestIdle;
            RunTestIdle:    w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   w_state_next = tms_i ? SelectIrScan   : CaptureDr;
            CaptureDr:      w_state_next = tms_i ? Exit1Dr        : ShiftDr;
            ShiftDr:        w_state_next = tms_i ? Exit1Dr        : ShiftDr;
            Exit1Dr:        w_state_next = tms_i ? UpdateDr       : PauseDr;
            PauseDr:        w_state_next = tms_i ? Exit2Dr        : PauseDr;
            Exit2Dr:        w_state_next = tms_i ? UpdateDr       : ShiftDr;
            UpdateDr:       w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   w_state_next = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:      w_state_next = tms_i ? Exit1Ir        : ShiftIr;
            ShiftIr:        w_state_next = tms_i ? Exit1Ir        : ShiftIr;
            Exit1Ir:        w_state_next = tms_i ? UpdateIr       : PauseIr;
            PauseIr:        w_state_next = tms_i ? Exit2Ir        : PauseIr;
            Exit2Ir:        w_state_next = tms_i ? UpdateIr       : ShiftIr;
            UpdateIr:       w_state_next = tms_i ? SelectDrScan   : RunTestIdle;
            default:        w_state_next = TestLogicReset;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register: shift stage plus the active IR. The active IR
    // only changes in UpdateIr / TestLogicReset, so selects decoded from
    // it stay stable across any DR scan.
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_ir       <= IrLength'(IDCODE);
            r_ir_shift <= '0;
        end else begin
            unique case (r_state)
                TestLogicReset: r_ir       <= IrLength'(IDCODE);
                CaptureIr:      r_ir_shift <= IrLength'(1);
                ShiftIr:        r_ir_shift <= {td_i, r_ir_shift[IrLength-1:1]};
                UpdateIr:       r_ir       <= r_ir_shift;
                default:        ;
            endcase
        end
    end

    assign w_sel_idcode = (r_ir == IrLength'(IDCODE));
    assign w_sel_dtmcs  = (r_ir == IrLength'(DTMCSR));
    assign w_sel_dmi    = (r_ir == IrLength'(DMIACCESS));
    // Every encoding not otherwise claimed (incl. BYPASS0/BYPASS1) is bypass.
    assign w_sel_bypass = !(w_sel_idcode || w_sel_dtmcs || w_sel_dmi);

    // ------------------------------------------------------------------
    // Internal data registers
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_idcode <= IdcodeValue;
            r_bypass <= 1'b0;
        end else if (r_state == CaptureDr) begin
            if (w_sel_idcode) r_idcode <= IdcodeValue;
            if (w_sel_bypass) r_bypass <= 1'b0;
        end else if (r_state == ShiftDr) begin
            if (w_sel_idcode) r_idcode <= {td_i, r_idcode[31:1]};
            if (w_sel_bypass) r_bypass <= td_i;
        end
    end

    // ------------------------------------------------------------------
    // TDO mux, retimed to the falling edge so the host samples a stable
    // bit on the following rising edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_tdo = r_bypass;
        if (r_state == ShiftIr)  w_tdo = r_ir_shift[0];
        else if (w_sel_idcode)   w_tdo = r_idcode[0];
        else if (w_sel_dtmcs)    w_tdo = dtmcs_tdo_i;
        else if (w_sel_dmi)      w_tdo = dmi_tdo_i;
    end

    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_td     <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_td     <= w_tdo;
            r_tdo_oe <= (r_state == ShiftIr) || (r_state == ShiftDr);
        end
    end

    assign td_o           = r_td;
    assign tdo_oe_o       = r_tdo_oe;
    assign tdi_o          = td_i;
    assign capture_o      = (r_state == CaptureDr);
    assign shift_o        = (r_state == ShiftDr);
    assign update_o       = (r_state == UpdateDr);
    assign dtmcs_select_o = w_sel_dtmcs;
    assign dmi_select_o   = w_sel_dmi;
    assign dmi_clear_o    = (r_state == TestLogicReset);

endmodule
`default_nettype wire

// File: tb/tb_dtm_jtag_tap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_dtm_jtag_tap
// Purpose : Self-checking bench for dtm_jtag_tap. Stimulus queues the TDO
//           bit it expects for every shift cycle; a monitor pops and compares
//           whenever tdo_oe_o marks a valid TDO bit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dtm_jtag_tap;

    localparam logic [31:0] EXP_IDCODE = 32'h0000_0001;

    logic tck = 1'b0;
    logic trst_ni, tms_i, td_i, dtmcs_tdo_i, dmi_tdo_i;
    logic td_o, tdo_oe_o, tdi_o, capture_o, shift_o, update_o;
    logic dtmcs_select_o, dmi_select_o, dmi_clear_o;

    logic q[$];
    logic e_bit;
    int   n_vec = 0;
    int   n_err = 0;
    int   cap_cnt = 0;
    int   shf_cnt = 0;
    int   upd_cnt = 0;

    dtm_jtag_tap dut (
        .tck_i          (tck),
        .trst_ni        (trst_ni),
        .tms_i          (tms_i),
        .td_i           (td_i),
        .td_o           (td_o),
        .tdo_oe_o       (tdo_oe_o),
        .tdi_o          (tdi_o),
        .capture_o      (capture_o),
        .shift_o        (shift_o),
        .update_o       (update_o),
        .dtmcs_select_o (dtmcs_select_o),
        .dmi_select_o   (dmi_select_o),
        .dmi_clear_o    (dmi_clear_o),
        .dtmcs_tdo_i    (dtmcs_tdo_i),
        .dmi_tdo_i      (dmi_tdo_i)
    );

    always #10 tck = ~tck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: td_o / tdo_oe_o only move on the falling edge, so they are
    // sampled just after the rising edge.
    always @(posedge tck) begin
        #1;
        if (tdo_oe_o === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL tdo_extra: td_o=%b with tdo_oe_o high but no bit expected", td_o);
            end else begin
                e_bit = q.pop_front();
                if (td_o !== e_bit) begin
                    n_err++;
                    $display("FAIL tdo_bit: got %b, expected %b", td_o, e_bit);
                end
            end
        end
    end

    always @(negedge tck) begin
        if (capture_o === 1'b1) cap_cnt++;
        if (shift_o   === 1'b1) shf_cnt++;
        if (update_o  === 1'b1) upd_cnt++;
    end

    // One TCK cycle: drive at rising edge + 1, return at next rising edge + 1.
    task automatic step(input logic tms, input logic tdi = 1'b0, input logic dmi = 1'b0,
                        input bit push = 1'b0, input logic exp = 1'b0);
        tms_i     = tms;
        td_i      = tdi;
        dmi_tdo_i = dmi;
        if (push) q.push_back(exp);
        @(posedge tck);
        #1;
    endtask

    // From RunTestIdle: IR scan of val, back to RunTestIdle.
    // CaptureIr loads 00001, so the bits shifted out are 1,0,0,0,0.
    task automatic ir_scan(input logic [4:0] val);
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 5; i++)
            step((i == 4), val[i], 1'b0, 1'b1, (i == 0));
        step(1'b1); step(1'b0);
    endtask

    task automatic drained(input string name);
        check(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [40:0] dmi_bits;
        logic [40:0] tdi_bits;
        logic [3:0]  byp_in;

        trst_ni = 1'b0; tms_i = 1'b1; td_i = 1'b0;
        dtmcs_tdo_i = 1'b0; dmi_tdo_i = 1'b0;
        repeat (2) @(posedge tck);
        #1;
        // Reset state
        check("rst_dmi_clear", dmi_clear_o, 1);
        check("rst_strobes",   {capture_o, shift_o, update_o}, 0);
        check("rst_selects",   {dtmcs_select_o, dmi_select_o}, 0);
        check("rst_tdo",       {td_o, tdo_oe_o}, 0);
        check("rst_ir",        dut.r_ir, 5'h01);
        #4 trst_ni = 1'b1;
        @(posedge tck); #1;

        // Five TMS=1 cycles -> TestLogicReset
        repeat (5) step(1'b1);
        check("tlr_dmi_clear", dmi_clear_o, 1);
        check("tlr_strobes",   {capture_o, shift_o, update_o}, 0);
        check("tlr_ir",        dut.r_ir, 5'h01);

        // IDCODE DR scan
        step(1'b0); step(1'b1); step(1'b0);
        check("id_capture", capture_o, 1);
        step(1'b0);
        check("id_shift", shift_o, 1);
        for (int i = 0; i < 32; i++)
            step((i == 31), 1'b0, 1'b0, 1'b1, EXP_IDCODE[i]);
        check("id_exit_oe_pending", shift_o, 0);
        step(1'b1);
        check("id_update", update_o, 1);
        step(1'b0);
        drained("id_all_bits_out");

        // IR scan to DMIACCESS
        ir_scan(5'h11);
        check("dmi_sel_after_ir", {dmi_select_o, dtmcs_select_o}, 2'b10);
        drained("ir_all_bits_out");

        // 41-bit DMIACCESS DR scan
        dmi_bits = 41'h0A5_C3F0_96E1;
        tdi_bits = 41'h13C_5A0F_7722;
        cap_cnt = 0; shf_cnt = 0; upd_cnt = 0;
        step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 41; i++) begin
            step((i == 40), tdi_bits[i], dmi_bits[i], 1'b1, dmi_bits[i]);
            if (i % 10 == 3) check("tdi_forward", tdi_o, tdi_bits[i]);
        end
        step(1'b1); step(1'b0);
        check("dmi_capture_cycles", cap_cnt, 1);
        check("dmi_shift_cycles",   shf_cnt, 41);
        check("dmi_update_cycles",  upd_cnt, 1);
        drained("dmi_all_bits_out");

        // Unmapped IR 0x07 -> bypass with one-bit delay
        ir_scan(5'h07);
        check("byp_selects", {dmi_select_o, dtmcs_select_o}, 0);
        byp_in = 4'b1101;  // shifted as 1,0,1,1
        step(1'b1); step(1'b0); step(1'b0);
        step(1'b0, byp_in[0], 1'b0, 1'b1, 1'b0);
        step(1'b0, byp_in[1], 1'b0, 1'b1, 1'b1);
        step(1'b0, byp_in[2], 1'b0, 1'b1, 1'b0);
        step(1'b1, byp_in[3], 1'b0, 1'b1, 1'b1);
        step(1'b1); step(1'b0);
        drained("byp_all_bits_out");

        // Async reset in the middle of a DMIACCESS ShiftDr
        ir_scan(5'h11);
        drained("ir2_all_bits_out");
        step(1'b1); step(1'b0); step(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        upd_cnt = 0;
        tms_i = 1'b1;
        #4 trst_ni = 1'b0;
        #1;
        check("arst_dmi_clear", dmi_clear_o, 1);
        check("arst_ir",        dut.r_ir, 5'h01);
        check("arst_shift",     {shift_o, tdo_oe_o}, 0);
        check("arst_selects",   {dmi_select_o, dtmcs_select_o}, 0);
        repeat (2) @(posedge tck);
        #5 trst_ni = 1'b1;
        @(posedge tck); #1;
        check("arst_no_update", upd_cnt, 0);
        check("arst_still_tlr", dmi_clear_o, 1);
        drained("arst_bits_out");

        // PauseDr in a separate IDCODE scan
        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, EXP_IDCODE[0]);
        step(1'b0, 1'b0, 1'b0, 1'b1, EXP_IDCODE[1]);
        step(1'b1, 1'b0, 1'b0, 1'b1, EXP_IDCODE[2]);
        check("exit1_shift_low", shift_o, 0);
        step(1'b0);
        check("pause_shift_low", shift_o, 0);
        step(1'b0);
        check("pause_hold_low", {shift_o, tdo_oe_o}, 0);
        step(1'b1);
        check("exit2_shift_low", shift_o, 0);
        step(1'b0);
        check("reshift_high", shift_o, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, EXP_IDCODE[3]);
        step(1'b1);
        check("pause_update", update_o, 1);
        step(1'b0);
        drained("pause_bits_out");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtm_jtag_tap.md
Name: dtm_jtag_tap

Overview:
IEEE 1149.1 TAP controller for the RISC-V Debug Transport Module; it sits directly upstream of the DTM register block.
- Decodes TMS into the 16-state TAP FSM.
- Holds the instruction register.
- Implements the IDCODE and BYPASS data registers internally.
- Provides capture/shift/update strobes, register selects and the DMI clear request to the DTM register block.
- Multiplexes that block's serial outputs onto TDO.

Parameters:
IrLength, 5, instruction register width in bits.
IdcodeValue, 32'h0000_0001, IDCODE register content; bit 0 must be 1.

Ports:
tck_i  input  1  JTAG clock; the only clock.
trst_ni  input  1  asynchronous active-low reset.
tms_i  input  1  test mode select.
td_i  input  1  test data in.
td_o  output  1  test data out, driven on the falling edge of tck_i.
tdo_oe_o  output  1  TDO output enable, driven on the falling edge of tck_i.
tdi_o  output  1  td_i forwarded combinationally to the DTM register block.
capture_o  output  1  high while the FSM is in CaptureDr.
shift_o  output  1  high while the FSM is in ShiftDr.
update_o  output  1  high while the FSM is in UpdateDr.
dtmcs_select_o  output  1  IR holds DTMCSR (0x10).
dmi_select_o  output  1  IR holds DMIACCESS (0x11).
dmi_clear_o  output  1  high while the FSM is in TestLogicReset.
dtmcs_tdo_i  input  1  serial out of the dtmcs shift register.
dmi_tdo_i  input  1  serial out of the dmiaccess shift register.

Behaviour:
- Clocking and reset:
  - Single clock tck_i. Reset trst_ni is asynchronous, active-low.
  - FSM, IR, IDCODE and bypass registers update on the rising edge of tck_i.
  - td_o and tdo_oe_o registers update on the falling edge of tck_i.
- Reset values:
  - FSM = TestLogicReset; IR = IDCODE (0x01); IR shift register = 0.
  - IDCODE shift register = IdcodeValue; bypass bit = 0.
  - td_o = 0, tdo_oe_o = 0.
  - Outputs under reset: capture_o, shift_o and update_o are low; dtmcs_select_o and dmi_select_o are low; dmi_clear_o is high.
- FSM states (standard transitions; the next state for TMS=1 is given in brackets):
  - TestLogicReset: TMS=0 -> RunTestIdle [stay].
  - RunTestIdle: stay [SelectDrScan].
  - SelectDrScan: CaptureDr [SelectIrScan].
  - CaptureDr: ShiftDr [Exit1Dr].
  - ShiftDr: stay [Exit1Dr].
  - Exit1Dr: PauseDr [UpdateDr].
  - PauseDr: stay [Exit2Dr].
  - Exit2Dr: ShiftDr [UpdateDr].
  - UpdateDr: RunTestIdle [SelectDrScan].
  - SelectIrScan: CaptureIr [TestLogicReset].
  - The IR branch (CaptureIr ... UpdateIr) mirrors the DR branch.
  - Five consecutive TMS=1 cycles reach TestLogicReset from any state.
- IR handling:
  - CaptureIr: IR shift register loads 5'b00001.
  - ShiftIr: IR shift register <= {td_i, ir_shift[IrLength-1:1]}.
  - UpdateIr: IR <= IR shift register.
  - TestLogicReset: IR <= IDCODE.
  - Encodings: BYPASS0 = 0x00, IDCODE = 0x01, DTMCSR = 0x10, DMIACCESS = 0x11, BYPASS1 = 0x1F. Any other value selects bypass.
- Selects are decoded combinationally from the IR and are stable through any DR scan.
- Internal DR registers:
  - IDCODE selected: CaptureDr loads IdcodeValue; ShiftDr shifts right, with td_i entering at the MSB.
  - Bypass selected: CaptureDr loads 0; ShiftDr loads td_i.
- TDO multiplexing (value registered on the falling edge):
  - In ShiftIr: ir_shift[0].
  - Otherwise by IR: IDCODE -> idcode[0]; DTMCSR -> dtmcs_tdo_i; DMIACCESS -> dmi_tdo_i; bypass -> bypass bit.
  - tdo_oe_o = (ShiftIr or ShiftDr), also registered on the falling edge.
- Strobes:
  - capture_o and update_o are exactly one tck cycle wide per DR scan.
  - shift_o is high for one cycle per ShiftDr cycle and deasserts in PauseDr and Exit states.
  - None of the DR strobes assert during IR scans.
- Async reset mid-scan: all state returns to reset values immediately; no update strobe is generated.

Decomposition:
- Package dm (shared):
  - tap_state_e: 16-entry enum.
  - dtm_ir_e: BYPASS0, IDCODE, DTMCSR, DMIACCESS, BYPASS1.
  - IR width constant.
- Sub-module: none. A single module holds the FSM, IR, DR registers and TDO mux.

Test Plan:
- Reset, then 5 cycles of TMS=1 -> FSM in TestLogicReset, dmi_clear_o=1, IR=0x01, all strobes low.
- TMS sequence 0,1,0,0, then 32 ShiftDr cycles with TMS=1 on the last -> td_o streams 32'h0000_0001 LSB first; tdo_oe_o high for exactly 32 falling edges.
- IR scan shifting in 0x11 LSB first -> td_o returns 1,0,0,0,0; after UpdateIr dmi_select_o=1 and dtmcs_select_o=0.
- With DMIACCESS selected, 41-bit DR scan:
  - capture_o high for 1 cycle, shift_o for 41 cycles, then update_o for 1 cycle.
  - tdi_o equals td_i.
  - td_o equals dmi_tdo_i sampled at each falling edge.
- IR=0x07 (unmapped), shift 1,0,1,1 through DR -> td_o yields 0,1,0,1 (one-bit delay); both selects low.
- trst_ni pulsed low during ShiftDr of a DMIACCESS scan -> FSM=TestLogicReset, IR=0x01, update_o never asserts, dmi_clear_o=1; PauseDr entered in a separate scan -> shift_o low there.
